// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg: shared state encoding, digit-count derivation and BCD constants.
//   state_t   : FSM state encoding driven onto the timer's 3-bit state port
//   BCD_MAX   : wrap value for seconds and minute digits
//   TENS_WRAP : wrap value for the tens-of-seconds digit
//   ndig()    : total digit count (secs + tens_secs + minute digits)
package bcd_countdown_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] TENS_WRAP = 4'd5;

    function automatic int ndig(input int min_digits);
        return min_digits + 2;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// bcd_digit_down: one BCD digit register with shift-load and borrow-chained decrement.
//   CLK        : clock
//   zero       : synchronous force to 0 (highest priority)
//   load       : take load_val (keypad shift-in)
//   load_val   : value to load
//   borrow_in  : decrement request from the digit below (or the tick for secs)
//   value      : current digit
//   borrow_out : this digit wraps, so the digit above must decrement
//   is_zero    : digit currently reads 0
module bcd_digit_down #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic       CLK,
    input  logic       zero,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out,
    output logic       is_zero
);

    assign is_zero    = value == 4'd0;
    assign borrow_out = borrow_in && is_zero;

    always_ff @(posedge CLK) begin
        if (zero)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (borrow_in)
            value <= is_zero ? WRAP : value - 4'd1;
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: keypad-loaded BCD countdown timer (microwave style) with run/pause/cancel FSM.
//   CLK         : clock, all state on rising edge
//   clear       : synchronous active-high reset
//   tick        : 1 Hz one-cycle strobe (enable, not a clock)
//   digit       : keypad BCD digit, qualified by digit_valid
//   start/pause/cancel : one-cycle control strobes
//   time_bcd    : [3:0] secs, [7:4] tens_secs, upper nibbles minutes (LS first)
//   state       : FSM state encoding
//   running     : registered, high only in RUN
//   timer_done  : registered, high only in DONE
//   done_pulse  : registered, high on the first DONE cycle
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter  int MIN_DIGITS = 1,
    localparam int NDIG       = ndig(MIN_DIGITS)
) (
    input  logic            CLK,
    input  logic            clear,
    input  logic            tick,
    input  logic [3:0]      digit,
    input  logic            digit_valid,
    input  logic            start,
    input  logic            pause,
    input  logic            cancel,
    output logic [4*NDIG-1:0] time_bcd,
    output logic [2:0]      state,
    output logic            running,
    output logic            timer_done,
    output logic            done_pulse
);

    localparam int TW = 4 * NDIG;

    state_t          cur;
    state_t          nxt;
    logic [NDIG:0]   borrow;
    logic [NDIG-1:0] is_zero;
    logic            all_zero;
    logic            time_one;
    logic            underflow;
    logic            dv_ok;
    logic            start_ok;
    logic            shift_en;
    logic            dec_en;
    logic            zero_all;

    assign state     = cur;
    assign all_zero  = &is_zero;
    assign time_one  = time_bcd == TW'(1);
    assign underflow = borrow[NDIG];
    assign dv_ok     = digit_valid && digit <= BCD_MAX;
    // pause outranks start even where pause itself has no effect
    assign start_ok  = start && !pause && !all_zero;
    assign dec_en    = cur == ST_RUN && tick && !pause && !cancel;
    assign shift_en  = dv_ok && !cancel && (cur == ST_IDLE || cur == ST_DONE || (cur == ST_SET && !start_ok));
    // RUN never holds zero, so underflow is only a safety net that lands in a clean DONE
    assign zero_all  = clear || cancel || underflow;
    assign borrow[0] = dec_en;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic [3:0] src;
        if (i == 0) begin : g_lsd
            assign src = digit;
        end else begin : g_upper
            assign src = time_bcd[4*(i-1) +: 4];
        end
        bcd_digit_down #(
            .WRAP(i == 1 ? TENS_WRAP : BCD_MAX)
        ) u_dig (
            .CLK       (CLK),
            .zero      (zero_all),
            .load      (shift_en),
            .load_val  (src),
            .borrow_in (borrow[i]),
            .value     (time_bcd[4*i +: 4]),
            .borrow_out(borrow[i+1]),
            .is_zero   (is_zero[i])
        );
    end

    always_comb begin
        nxt = cur;
        if (cancel)
            nxt = ST_IDLE;
        else
            case (cur)
                ST_IDLE, ST_DONE: nxt = dv_ok ? ST_SET : cur;
                ST_SET:           nxt = start_ok ? ST_RUN : cur;
                ST_RUN:           nxt = pause ? ST_PAUSE : (dec_en && (time_one || underflow)) ? ST_DONE : cur;
                ST_PAUSE:         nxt = start_ok ? ST_RUN : cur;
                default:          nxt = ST_IDLE;
            endcase
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            cur        <= ST_IDLE;
            running    <= 1'b0;
            timer_done <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            cur        <= nxt;
            running    <= nxt == ST_RUN;
            timer_done <= nxt == ST_DONE;
            done_pulse <= nxt == ST_DONE && cur != ST_DONE;
        end
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter MIN_DIGITS, default 1, number of BCD minute digits (legal range 1..3).
REQ-002 Derived constant NDIG = MIN_DIGITS + 2 (secs, tens_secs, minute digits).
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle 1 Hz strobe; the timer is never clocked by it.
REQ-006 digit  input  4  keypad BCD digit.
REQ-007 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-008 start  input  1  one-cycle strobe: begin or resume countdown.
REQ-009 pause  input  1  one-cycle strobe: suspend countdown.
REQ-010 cancel  input  1  one-cycle strobe: abort and zero the timer.
REQ-011 time_bcd  output  4*NDIG  digits, [3:0]=secs, [7:4]=tens_secs, upper nibbles minutes (LS minute first).
REQ-012 state  output  3  current FSM state encoding.
REQ-013 running  output  1  high only in RUN; gates the magnetron.
REQ-014 timer_done  output  1  level, high only in DONE.
REQ-015 done_pulse  output  1  one-cycle pulse on the cycle DONE is entered.

Function
REQ-016 FSM states SHALL be IDLE, SET, RUN, PAUSE, DONE.
REQ-017 IDLE: time_bcd all zero; digit_valid with digit<=9 -> SET and shift digit in.
REQ-018 Shift-in: each nibble moves one position up, digit enters nibble 0, top nibble is discarded.
REQ-019 SET: further valid digits shift in; digit>9 SHALL be ignored in every state.
REQ-020 SET/PAUSE + start with time_bcd nonzero -> RUN; start with all-zero time_bcd is ignored.
REQ-021 RUN + tick: decrement by one second, registered, visible the cycle after tick.
REQ-022 Decrement: secs 0->9 with borrow; tens_secs 0->5 with borrow; minute digits 0->9 with borrow.
REQ-023 Entered tens_secs 6..9 SHALL count down normally (e.g. 0:90 -> 0:89), no normalisation.
REQ-024 Decrement reaching all-zero SHALL enter DONE in the same update; done_pulse high that cycle.
REQ-025 RUN + pause -> PAUSE, time held; tick in PAUSE, SET, IDLE, DONE ignored.
REQ-026 cancel in SET, RUN or PAUSE -> IDLE with time_bcd zeroed, next cycle.
REQ-027 DONE: time_bcd zero, timer_done high until cancel or digit_valid; digit_valid -> SET with digit shifted in.
REQ-028 digit_valid in RUN or PAUSE SHALL be ignored.
REQ-029 Same-cycle priority: clear > cancel > pause > start > tick > digit_valid.
REQ-030 RUN with pause and tick together: no decrement, enter PAUSE.
REQ-031 SET with start and digit_valid together: start acts, digit dropped.
REQ-032 running and timer_done SHALL be registered outputs, never both high.

Reset
REQ-033 clear high at a rising edge SHALL force IDLE, time_bcd=0, running=0, timer_done=0, done_pulse=0.
REQ-034 clear mid-RUN SHALL abort without done_pulse.
REQ-035 No output SHALL depend combinationally on clear.

Structure
REQ-036 Shared package holds state encoding, NDIG derivation, and BCD constants (max 9, tens_secs wrap 5).
REQ-037 One sub-module, bcd_digit_down, parametrised by wrap value: load/shift, decrement with borrow-in/out, zero flag.
REQ-038 Top level instantiates NDIG bcd_digit_down via generate and holds the FSM.

Verification
REQ-039 MIN_DIGITS=1: digits 1,3,0, start, 2 ticks -> time_bcd 1:30, 1:29, 1:28.
REQ-040 Load 0:01, start, tick -> time_bcd 0, DONE, done_pulse exactly one cycle, running low.
REQ-041 Load 0:90 then count 0:90->0:89; at 1:00 a tick -> 0:59 (borrow).
REQ-042 RUN: pause+tick same cycle -> no decrement, PAUSE; start -> RUN resumes from held value.
REQ-043 MIN_DIGITS=3: enter 9,9,9,5,9 (99:959 shown as 999:59) -> 10 ticks -> 999:49; clear mid-RUN -> IDLE zero, no done_pulse.
REQ-044 start at all-zero in IDLE -> stays IDLE; digit 0xA in SET -> time_bcd unchanged.
